// File: rtl/my_axi4_lite_pkg.sv
// my_axi4_lite_pkg: shared AXI4-Lite response codes and command/response records
package my_axi4_lite_pkg;
  localparam int AXI4_LITE_ADDR_W = 4;
  localparam int AXI4_LITE_DATA_W = 32;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi4_lite_resp_t;
  typedef struct packed {
    logic                          wr;
    logic [AXI4_LITE_ADDR_W-1:0]   addr;
    logic [AXI4_LITE_DATA_W-1:0]   wdata;
    logic [AXI4_LITE_DATA_W/8-1:0] wstrb;
  } axi4_lite_cmd_t;
  typedef struct packed {
    logic                        wr;
    logic [AXI4_LITE_DATA_W-1:0] rdata;
    axi4_lite_resp_t             resp;
  } axi4_lite_rsp_t;
endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-Lite bus bundle with master and slave views
interface axi4_lite_if #(
  parameter int AXI4_LITE_ADDR_BIT_WIDTH = 4,
  parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
);
  logic                                  awvalid;
  logic                                  awready;
  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                            awprot;
  logic                                  wvalid;
  logic                                  wready;
  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   wdata;
  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                                  bvalid;
  logic                                  bready;
  logic [1:0]                            bresp;
  logic                                  arvalid;
  logic                                  arready;
  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                            arprot;
  logic                                  rvalid;
  logic                                  rready;
  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                            rresp;
  modport mst_port (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slv_port (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/my_axi4_lite_mst_bridge.sv
// my_axi4_lite_mst_bridge: command stream to single-outstanding AXI4-Lite master with error count
module my_axi4_lite_mst_bridge
  import my_axi4_lite_pkg::*;
#(
  parameter int AXI4_LITE_ADDR_BIT_WIDTH = AXI4_LITE_ADDR_W,
  parameter int AXI4_LITE_DATA_BIT_WIDTH = AXI4_LITE_DATA_W,
  parameter int ERR_CNT_BIT_WIDTH        = 16
) (
  input  logic                                  i_clk,
  input  logic                                  i_async_rst_n,
  input  logic                                  i_cmd_valid,
  output logic                                  o_cmd_ready,
  input  logic                                  i_cmd_wr,
  input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                                  o_rsp_valid,
  input  logic                                  i_rsp_ready,
  output logic                                  o_rsp_wr,
  output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                            o_rsp_resp,
  output logic [ERR_CNT_BIT_WIDTH-1:0]          o_err_cnt,
  axi4_lite_if.mst_port                         if_m_axi4_lite
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} mst_state_t;
  mst_state_t                   state_q, state_d;
  axi4_lite_cmd_t               cmd_q, cmd_d;
  axi4_lite_rsp_t               rsp_q, rsp_d;
  logic                         awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic                         bready_q, bready_d, rready_q, rready_d, rsp_valid_q, rsp_valid_d;
  logic                         live_q, live_d;
  logic [ERR_CNT_BIT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  // live_q holds command ready low until the first edge after reset release
  assign o_cmd_ready            = live_q && state_q == IDLE;
  assign o_rsp_valid            = rsp_valid_q;
  assign o_rsp_wr               = rsp_q.wr;
  assign o_rsp_rdata            = rsp_q.rdata;
  assign o_rsp_resp             = rsp_q.resp;
  assign o_err_cnt              = err_cnt_q;
  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.awaddr  = cmd_q.addr;
  assign if_m_axi4_lite.awprot  = 3'b000;
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.wdata   = cmd_q.wdata;
  assign if_m_axi4_lite.wstrb   = cmd_q.wstrb;
  assign if_m_axi4_lite.bready  = bready_q;
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.araddr  = cmd_q.addr;
  assign if_m_axi4_lite.arprot  = 3'b000;
  assign if_m_axi4_lite.rready  = rready_q;
  // next state, next registered bus outputs and response capture
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    live_d      = 1'b1;
    err_cnt_d   = err_cnt_q;
    unique case (state_q)
      IDLE: if (i_cmd_valid && o_cmd_ready) begin
        cmd_d.wr    = i_cmd_wr;
        cmd_d.addr  = i_cmd_addr;
        cmd_d.wdata = i_cmd_wdata;
        cmd_d.wstrb = i_cmd_wstrb;
        awvalid_d   = i_cmd_wr;
        wvalid_d    = i_cmd_wr;
        arvalid_d   = !i_cmd_wr;
        state_d     = i_cmd_wr ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        if (awvalid_q && if_m_axi4_lite.awready) awvalid_d = 1'b0;
        if (wvalid_q && if_m_axi4_lite.wready) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: if (if_m_axi4_lite.bvalid && bready_q) begin
        bready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_d.wr    = 1'b1;
        rsp_d.rdata = '0;
        rsp_d.resp  = axi4_lite_resp_t'(if_m_axi4_lite.bresp);
        state_d     = RSP;
      end
      RD_REQ: if (if_m_axi4_lite.arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RD_RESP;
      end
      RD_RESP: if (if_m_axi4_lite.rvalid && rready_q) begin
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_d.wr    = 1'b0;
        rsp_d.rdata = if_m_axi4_lite.rdata;
        rsp_d.resp  = axi4_lite_resp_t'(if_m_axi4_lite.rresp);
        state_d     = RSP;
      end
      RSP: if (i_rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rsp_valid_d && !rsp_valid_q && rsp_d.resp != OKAY && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
  end
  // state and output registers, cleared asynchronously so valids drop at once
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      live_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      live_q      <= live_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_my_axi4_lite_mst_bridge.sv
// tb_my_axi4_lite_mst_bridge: directed checks of the AXI4-Lite master bridge against a model slave
module tb_my_axi4_lite_mst_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_wr = 1'b0, rsp_ready = 1'b1;
  logic [3:0]  cmd_addr = '0, cmd_wstrb = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_wr;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] err_cnt;
  logic        cmd_valid2 = 1'b0, cmd_wr2 = 1'b0, rsp_ready2 = 1'b1;
  logic [3:0]  cmd_addr2 = '0, cmd_wstrb2 = '0;
  logic [31:0] cmd_wdata2 = '0;
  logic        cmd_ready2, rsp_valid2, rsp_wr2;
  logic [31:0] rsp_rdata2;
  logic [1:0]  rsp_resp2, err_cnt2;
  logic        aw_en = 1'b1, w_en = 1'b1;
  logic [1:0]  slv_resp = 2'b00;
  logic        aw_got, w_got, ar_got;
  logic [3:0]  aw_addr, ar_addr;
  logic [31:0] w_data;
  logic [31:0] mem [4];
  int          b_hs_cnt;
  int          cyc = 0;
  int          vectors = 0, miscompares = 0;

  axi4_lite_if #(.AXI4_LITE_ADDR_BIT_WIDTH(4), .AXI4_LITE_DATA_BIT_WIDTH(32)) m_if ();
  axi4_lite_if #(.AXI4_LITE_ADDR_BIT_WIDTH(4), .AXI4_LITE_DATA_BIT_WIDTH(32)) s_if ();

  my_axi4_lite_mst_bridge dut (
    .i_clk(clk), .i_async_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_wr(cmd_wr),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_wr(rsp_wr),
    .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_err_cnt(err_cnt),
    .if_m_axi4_lite(m_if)
  );

  my_axi4_lite_mst_bridge #(.ERR_CNT_BIT_WIDTH(2)) dut2 (
    .i_clk(clk), .i_async_rst_n(rst_n),
    .i_cmd_valid(cmd_valid2), .o_cmd_ready(cmd_ready2), .i_cmd_wr(cmd_wr2),
    .i_cmd_addr(cmd_addr2), .i_cmd_wdata(cmd_wdata2), .i_cmd_wstrb(cmd_wstrb2),
    .o_rsp_valid(rsp_valid2), .i_rsp_ready(rsp_ready2), .o_rsp_wr(rsp_wr2),
    .o_rsp_rdata(rsp_rdata2), .o_rsp_resp(rsp_resp2), .o_err_cnt(err_cnt2),
    .if_m_axi4_lite(s_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign m_if.awready = aw_en;
  assign m_if.wready  = w_en;
  assign m_if.arready = 1'b1;

  // register-file slave: response one edge after the request handshake(s) complete
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_addr <= '0; ar_addr <= '0; w_data <= '0;
      m_if.bvalid <= 1'b0; m_if.bresp <= '0;
      m_if.rvalid <= 1'b0; m_if.rresp <= '0; m_if.rdata <= '0;
      b_hs_cnt <= 0;
    end else begin
      if (m_if.awvalid && m_if.awready) begin aw_got <= 1'b1; aw_addr <= m_if.awaddr; end
      if (m_if.wvalid && m_if.wready) begin w_got <= 1'b1; w_data <= m_if.wdata; end
      if (aw_got && w_got) begin
        mem[aw_addr[3:2]] <= w_data;
        aw_got <= 1'b0; w_got <= 1'b0;
        m_if.bvalid <= 1'b1; m_if.bresp <= slv_resp;
      end
      if (m_if.bvalid && m_if.bready) begin m_if.bvalid <= 1'b0; b_hs_cnt <= b_hs_cnt + 1; end
      if (m_if.arvalid && m_if.arready) begin ar_got <= 1'b1; ar_addr <= m_if.araddr; end
      if (ar_got) begin
        ar_got <= 1'b0;
        m_if.rvalid <= 1'b1; m_if.rdata <= mem[ar_addr[3:2]]; m_if.rresp <= slv_resp;
      end
      if (m_if.rvalid && m_if.rready) m_if.rvalid <= 1'b0;
    end
  end

  // second slave answers every read with DECERR
  assign s_if.awready = 1'b1;
  assign s_if.wready  = 1'b1;
  assign s_if.bvalid  = 1'b0;
  assign s_if.bresp   = 2'b00;
  assign s_if.arready = 1'b1;
  assign s_if.rdata   = '0;
  assign s_if.rresp   = 2'b11;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) s_if.rvalid <= 1'b0;
    else s_if.rvalid <= (s_if.rvalid && !s_if.rready) || (s_if.arvalid && s_if.arready);

  task automatic do_cmd(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                        output logic r_wr, output logic [31:0] r_data, output logic [1:0] r_resp,
                        output int lat);
    int t0;
    bit ok;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = 4'hF;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) if (cmd_ready) ok = 1; else @(negedge clk);
    t0 = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (ok) for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    lat = cyc - t0;
    r_wr = rsp_wr; r_data = rsp_rdata; r_resp = rsp_resp;
    if (!ok || !rsp_valid) begin
      vectors++; miscompares++;
      $display("FAIL cmd_timeout: ready=%0b rsp_valid=%0b, required a response", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready} !== 5'b0) begin
      miscompares++; $display("FAIL rst_axi_handshake: got %b want 00000", {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready}); end
    vectors++; if ({m_if.awaddr, m_if.wdata, m_if.wstrb} !== 40'h0) begin
      miscompares++; $display("FAIL rst_axi_payload: got %h want 0", {m_if.awaddr, m_if.wdata, m_if.wstrb}); end
    vectors++; if (err_cnt !== 16'h0) begin miscompares++; $display("FAIL rst_err_cnt: got %h want 0", err_cnt); end
    vectors++; if ({rsp_wr, rsp_rdata, rsp_resp} !== 35'h0) begin
      miscompares++; $display("FAIL rst_rsp_payload: got %h want 0", {rsp_wr, rsp_rdata, rsp_resp}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write_read;
    logic w; logic [31:0] d; logic [1:0] r; int lat;
    do_cmd(1'b1, 4'h0, 32'h1234_5678, w, d, r, lat);
    vectors++; if ({w, r} !== 3'b100) begin miscompares++; $display("FAIL wr_rsp: got wr=%b resp=%b want wr=1 resp=00", w, r); end
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL wr_rdata: got %h want 0", d); end
    vectors++; if (lat != 3) begin miscompares++; $display("FAIL wr_latency: got %0d want 3", lat); end
    vectors++; if (m_if.awprot !== 3'b000 || m_if.arprot !== 3'b000) begin
      miscompares++; $display("FAIL prot: got aw=%b ar=%b want 000", m_if.awprot, m_if.arprot); end
    do_cmd(1'b0, 4'h0, 32'h0, w, d, r, lat);
    vectors++; if (d !== 32'h1234_5678) begin miscompares++; $display("FAIL rd_rdata: got %h want 12345678", d); end
    vectors++; if ({w, r} !== 3'b000) begin miscompares++; $display("FAIL rd_rsp: got wr=%b resp=%b want wr=0 resp=00", w, r); end
    vectors++; if (lat != 3) begin miscompares++; $display("FAIL rd_latency: got %0d want 3", lat); end
  endtask

  task automatic test_aw_w_independent;
    logic w; logic [31:0] d; logic [1:0] r; int lat, b0;
    aw_en = 1'b0;
    b0 = b_hs_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'h8; cmd_wdata = 32'hA5C3_0F96; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (m_if.awvalid !== 1'b1 || m_if.awaddr !== 4'h8) begin
        miscompares++; $display("FAIL aw_hold[%0d]: got awvalid=%b awaddr=%h want 1/8", i, m_if.awvalid, m_if.awaddr); end
      vectors++; if (m_if.wvalid !== (i == 0)) begin
        miscompares++; $display("FAIL w_drop[%0d]: got wvalid=%b want %b", i, m_if.wvalid, i == 0); end
      if (i == 3) aw_en = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    vectors++; if (rsp_valid !== 1'b1 || rsp_wr !== 1'b1 || rsp_resp !== 2'b00) begin
      miscompares++; $display("FAIL aw_w_rsp: got valid=%b wr=%b resp=%b want 1/1/00", rsp_valid, rsp_wr, rsp_resp); end
    repeat (3) @(negedge clk);
    vectors++; if (b_hs_cnt - b0 != 1) begin miscompares++; $display("FAIL b_handshakes: got %0d want 1", b_hs_cnt - b0); end
    do_cmd(1'b0, 4'h8, 32'h0, w, d, r, lat);
    vectors++; if (d !== 32'hA5C3_0F96) begin miscompares++; $display("FAIL aw_w_readback: got %h want a5c30f96", d); end
  endtask

  task automatic test_back_to_back;
    int acc [2];
    int nacc, nrsp, bad;
    logic [31:0] rd [2];
    logic [2:0] info [2];
    nacc = 0; nrsp = 0; bad = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h8765_4321; cmd_wstrb = 4'hF;
    for (int i = 0; i < 40 && nrsp < 2; i++) begin
      if (nacc == 1) cmd_wr = 1'b0;
      if (nacc == 2) cmd_valid = 1'b0;
      if (cmd_ready && (rsp_valid || m_if.awvalid || m_if.wvalid || m_if.arvalid || m_if.bready || m_if.rready)) bad++;
      if (rsp_valid) begin rd[nrsp] = rsp_rdata; info[nrsp] = {rsp_wr, rsp_resp}; nrsp++; end
      if (cmd_valid && cmd_ready && nacc < 2) begin acc[nacc] = cyc; nacc++; end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    vectors++; if (nrsp != 2 || nacc != 2) begin
      miscompares++; $display("FAIL b2b_count: got acc=%0d rsp=%0d want 2/2", nacc, nrsp); end
    else begin
      vectors++; if (info[0] !== 3'b100) begin miscompares++; $display("FAIL b2b_wr_rsp: got %b want 100", info[0]); end
      vectors++; if (info[1] !== 3'b000 || rd[1] !== 32'h8765_4321) begin
        miscompares++; $display("FAIL b2b_rd_rsp: got info=%b rdata=%h want 000/87654321", info[1], rd[1]); end
      vectors++; if (acc[1] - acc[0] < 4) begin
        miscompares++; $display("FAIL b2b_spacing: got %0d cycles want >=4", acc[1] - acc[0]); end
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL b2b_ready_outside_idle: got %0d cycles want 0", bad); end
  endtask

  task automatic test_rsp_backpressure;
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'h4;
    @(negedge clk);
    cmd_wr = 1'b1; cmd_addr = 4'hC; cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'hF;
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8765_4321 || rsp_wr !== 1'b0 || rsp_resp !== 2'b00) begin
        miscompares++; $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h wr=%b resp=%b want 1/87654321/0/00",
                                i, rsp_valid, rsp_rdata, rsp_wr, rsp_resp); end
      vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_no_accept[%0d]: got %b want 0", i, cmd_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_release: got rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    vectors++; if (rsp_valid !== 1'b1 || rsp_wr !== 1'b1) begin
      miscompares++; $display("FAIL bp_pending_wr: got valid=%b wr=%b want 1/1", rsp_valid, rsp_wr); end
  endtask

  task automatic test_errors;
    logic w; logic [31:0] d; logic [1:0] r; int lat;
    slv_resp = 2'b10;
    do_cmd(1'b1, 4'hC, 32'h1111_2222, w, d, r, lat);
    vectors++; if (r !== 2'b10 || err_cnt !== 16'd1) begin
      miscompares++; $display("FAIL err_slverr: got resp=%b cnt=%0d want 10/1", r, err_cnt); end
    slv_resp = 2'b11;
    do_cmd(1'b0, 4'hC, 32'h0, w, d, r, lat);
    vectors++; if (r !== 2'b11 || err_cnt !== 16'd2) begin
      miscompares++; $display("FAIL err_decerr: got resp=%b cnt=%0d want 11/2", r, err_cnt); end
    slv_resp = 2'b00;
    do_cmd(1'b0, 4'hC, 32'h0, w, d, r, lat);
    vectors++; if (r !== 2'b00 || err_cnt !== 16'd2 || d !== 32'h1111_2222) begin
      miscompares++; $display("FAIL err_okay: got resp=%b cnt=%0d rdata=%h want 00/2/11112222", r, err_cnt, d); end
  endtask

  task automatic test_err_saturation;
    int n;
    n = 0;
    cmd_valid2 = 1'b1;
    for (int i = 0; i < 200 && n < 5; i++) begin
      @(negedge clk);
      if (rsp_valid2) begin
        n++;
        if (n == 2) begin
          vectors++; if (err_cnt2 !== 2'd2) begin miscompares++; $display("FAIL sat_two: got %0d want 2", err_cnt2); end
        end
      end
    end
    cmd_valid2 = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (n != 5 || err_cnt2 !== 2'd3) begin
      miscompares++; $display("FAIL sat_five: got n=%0d cnt=%0d want 5/3", n, err_cnt2); end
  endtask

  task automatic test_mid_reset;
    logic w; logic [31:0] d; logic [1:0] r; int lat;
    aw_en = 1'b0; w_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++; if (m_if.awvalid !== 1'b1 || m_if.wvalid !== 1'b1) begin
      miscompares++; $display("FAIL mr_pre: got aw=%b w=%b want 1/1", m_if.awvalid, m_if.wvalid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (m_if.awvalid !== 1'b0 || m_if.wvalid !== 1'b0) begin
      miscompares++; $display("FAIL mr_valid_drop: got aw=%b w=%b want 0/0", m_if.awvalid, m_if.wvalid); end
    vectors++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || err_cnt !== 16'h0) begin
      miscompares++; $display("FAIL mr_outputs: got ready=%b rsp_valid=%b cnt=%0d want 0/0/0", cmd_ready, rsp_valid, err_cnt); end
    vectors++; if ({m_if.awaddr, m_if.wdata, m_if.wstrb} !== 40'h0) begin
      miscompares++; $display("FAIL mr_payload: got %h want 0", {m_if.awaddr, m_if.wdata, m_if.wstrb}); end
    aw_en = 1'b1; w_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mr_release_ready: got %b want 1", cmd_ready); end
    do_cmd(1'b0, 4'h0, 32'h0, w, d, r, lat);
    vectors++; if (d !== 32'h1234_5678 || r !== 2'b00) begin
      miscompares++; $display("FAIL mr_after: got rdata=%h resp=%b want 12345678/00", d, r); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_aw_w_independent();
    test_back_to_back();
    test_rsp_backpressure();
    test_errors();
    test_err_saturation();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
